// File: rtl/kt_pkg.sv
// Shared types for the KnightsTour command path: opcodes, cmd field slices,
// and the arbiter state encoding.
// cmd layout: {opcode[15:12], heading[11:4], sqrs[3:0]}.
package kt_pkg;

  localparam int CMD_W  = 16;
  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int HDG_HI = 11;
  localparam int HDG_LO = 4;
  localparam int SQR_HI = 3;
  localparam int SQR_LO = 0;

  typedef enum logic [3:0] {
    OP_CAL     = 4'h2,
    OP_MOVE    = 4'h4,
    OP_FANFARE = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_t;

  function automatic logic [3:0] cmd_opcode(input logic [CMD_W-1:0] c);
    return c[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [7:0] cmd_heading(input logic [CMD_W-1:0] c);
    return c[HDG_HI:HDG_LO];
  endfunction

  function automatic logic [3:0] cmd_sqrs(input logic [CMD_W-1:0] c);
    return c[SQR_HI:SQR_LO];
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Watchdog for one outstanding command: counts enabled cycles since the last
// clear and flags expiry on the TMO_CYC-th enabled cycle.
// Ports: clk, rst_n (async low), clr_i (zero count), en_i (count this cycle),
//        expired_o (combinational: enabled and count == TMO_CYC-1).
module cmd_watchdog #(
  parameter int unsigned          TMO_W   = 24,
  parameter logic [TMO_W-1:0]     TMO_CYC = 24'hFFFFFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TMO_W-1:0] LAST_CNT = TMO_CYC - 1'b1;

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by en_i so a stale count left after a timeout cannot re-fire in IDLE.
  assign expired_o = en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/cmd_arbiter_seq.sv
// Arbitrates the single cmd_proc command port between host and tour sources,
// one command outstanding at a time, with a completion watchdog.
// Ports: host_cmd/host_rdy -> host_clr/host_done; tour_cmd/tour_vld -> tour_ack;
//        cmd/cmd_rdy <- clr_cmd_rdy/send_resp to cmd_proc; owner/busy/cal_ok/tmo_err status.
module cmd_arbiter_seq
  import kt_pkg::*;
#(
  parameter int unsigned      TMO_W   = 24,
  parameter logic [TMO_W-1:0] TMO_CYC = 24'hFFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] host_cmd,
  input  logic             host_rdy,
  output logic             host_clr,
  output logic             host_done,
  input  logic [CMD_W-1:0] tour_cmd,
  input  logic             tour_vld,
  output logic             tour_ack,
  output logic [CMD_W-1:0] cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic             owner,
  output logic             busy,
  output logic             cal_ok,
  output logic             tmo_err
);

  arb_state_t       state_q;
  logic [CMD_W-1:0] cmd_q;
  logic             cmd_rdy_q;
  logic             owner_q;
  logic             busy_q;
  logic             cal_ok_q;
  logic             tmo_err_q;
  logic             host_done_q;
  logic             tour_ack_q;

  logic grant_host;
  logic grant_tour;
  logic wd_expired;

  // Host has strict priority; tour is only eligible once calibration is done.
  assign grant_host = (state_q == ST_IDLE) && host_rdy;
  assign grant_tour = (state_q == ST_IDLE) && !host_rdy && tour_vld && cal_ok_q;

  cmd_watchdog #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (grant_host || grant_tour),
    .en_i      (state_q != ST_IDLE),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      cal_ok_q    <= 1'b0;
      tmo_err_q   <= 1'b0;
      host_done_q <= 1'b0;
      tour_ack_q  <= 1'b0;
    end else begin
      host_done_q <= 1'b0;
      tour_ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_host || grant_tour) begin
            cmd_q     <= grant_host ? host_cmd : tour_cmd;
            owner_q   <= grant_tour;
            busy_q    <= 1'b1;
            tmo_err_q <= 1'b0;
            cmd_rdy_q <= 1'b1;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // send_resp is not expected before acceptance, so only the
          // watchdog can end the command here.
          if (wd_expired) begin
            tmo_err_q   <= 1'b1;
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b0;
            host_done_q <= !owner_q;
            tour_ack_q  <= owner_q;
            state_q     <= ST_IDLE;
          end else if (clr_cmd_rdy) begin
            cmd_rdy_q <= 1'b0;
            state_q   <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          // A real completion beats a coincident timeout.
          if (send_resp) begin
            busy_q      <= 1'b0;
            host_done_q <= !owner_q;
            tour_ack_q  <= owner_q;
            state_q     <= ST_IDLE;
            if (cmd_opcode(cmd_q) == OP_CAL) begin
              cal_ok_q <= 1'b1;
            end
          end else if (wd_expired) begin
            tmo_err_q   <= 1'b1;
            busy_q      <= 1'b0;
            host_done_q <= !owner_q;
            tour_ack_q  <= owner_q;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign host_clr  = grant_host;
  assign host_done = host_done_q;
  assign tour_ack  = tour_ack_q;
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign cal_ok    = cal_ok_q;
  assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_cmd_arbiter_seq.sv
// Bench for cmd_arbiter_seq: cycle-by-cycle vector table plus hand-written
// timeout, timeout/send_resp race and async-reset sequences.
// Inputs change at the falling edge; outputs are sampled 1ns later.
module tb_cmd_arbiter_seq;

  logic        clk;
  logic        rst_n;
  logic [15:0] host_cmd;
  logic        host_rdy;
  logic        host_clr;
  logic        host_done;
  logic [15:0] tour_cmd;
  logic        tour_vld;
  logic        tour_ack;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        owner;
  logic        busy;
  logic        cal_ok;
  logic        tmo_err;

  int total_cnt;
  int pass_cnt;

  cmd_arbiter_seq #(
    .TMO_W   (24),
    .TMO_CYC (24'd100)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host_cmd    (host_cmd),
    .host_rdy    (host_rdy),
    .host_clr    (host_clr),
    .host_done   (host_done),
    .tour_cmd    (tour_cmd),
    .tour_vld    (tour_vld),
    .tour_ack    (tour_ack),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .send_resp   (send_resp),
    .owner       (owner),
    .busy        (busy),
    .cal_ok      (cal_ok),
    .tmo_err     (tmo_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record = inputs held for n cycles, expected outputs checked each cycle.
  // flags = {host_clr, host_done, tour_ack, cmd_rdy, busy, owner, cal_ok, tmo_err}
  typedef struct {
    string       name;
    int          n;
    logic [15:0] hc;
    logic        hr;
    logic [15:0] tc;
    logic        tv;
    logic        clr;
    logic        sr;
    logic [7:0]  e_flags;
    logic [15:0] e_cmd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input int n,
                              input logic [15:0] hc, input logic hr,
                              input logic [15:0] tc, input logic tv,
                              input logic clr, input logic sr,
                              input logic [7:0] ef, input logic [15:0] ec);
    vec_t v;
    v.name = nm; v.n = n; v.hc = hc; v.hr = hr; v.tc = tc; v.tv = tv;
    v.clr = clr; v.sr = sr; v.e_flags = ef; v.e_cmd = ec;
    return v;
  endfunction

  function automatic logic [7:0] flags();
    return {host_clr, host_done, tour_ack, cmd_rdy, busy, owner, cal_ok, tmo_err};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [15:0] hc, input logic hr, input logic [15:0] tc,
                       input logic tv, input logic clr, input logic sr);
    host_cmd = hc; host_rdy = hr; tour_cmd = tc; tour_vld = tv;
    clr_cmd_rdy = clr; send_resp = sr;
  endtask

  initial begin
    int bad;
    int busy_cycles;

    total_cnt = 0;
    pass_cnt  = 0;
    rst_n     = 1'b0;
    drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick(); tick(); #1;
    chk("reset_flags", {24'h0, flags()}, 32'h0);
    chk("reset_cmd", {16'h0, cmd}, 32'h0);
    tick();
    rst_n = 1'b1;

    // Tour request before any calibration must be ignored.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(); drive(16'h0, 1'b0, 16'h4001, 1'b1, 1'b0, 1'b0); #1;
      if (cmd_rdy || busy || tour_ack) bad++;
    end
    chk("t1_tour_ignored_precal", bad, 0);
    chk("t1_cmd_untouched", {16'h0, cmd}, 32'h0);

    // Host calibrate, then host/tour contention, then idle strobes.
    vecs.push_back(mk("t2_grant",        1, 16'h2000, 1, 16'h0000, 0, 0, 0, 8'b10000000, 16'h0000));
    vecs.push_back(mk("t2_issue",        2, 16'h2000, 0, 16'h0000, 0, 0, 0, 8'b00011000, 16'h2000));
    vecs.push_back(mk("t2_accept",       1, 16'h2000, 0, 16'h0000, 0, 1, 0, 8'b00011000, 16'h2000));
    vecs.push_back(mk("t2_wait",        46, 16'h2000, 0, 16'h0000, 0, 0, 0, 8'b00001000, 16'h2000));
    vecs.push_back(mk("t2_resp",         1, 16'h2000, 0, 16'h0000, 0, 0, 1, 8'b00001000, 16'h2000));
    vecs.push_back(mk("t2_done",         1, 16'h2000, 0, 16'h0000, 0, 0, 0, 8'b01000010, 16'h2000));
    vecs.push_back(mk("t2_quiet",        1, 16'h2000, 0, 16'h0000, 0, 0, 0, 8'b00000010, 16'h2000));
    vecs.push_back(mk("t3_both_req",     1, 16'h5BF1, 1, 16'h4002, 1, 0, 0, 8'b10000010, 16'h2000));
    vecs.push_back(mk("t3_host_issue",   1, 16'h5BF1, 0, 16'h4002, 1, 1, 0, 8'b00011010, 16'h5BF1));
    vecs.push_back(mk("t3_host_wait",    1, 16'h5BF1, 0, 16'h4002, 1, 0, 1, 8'b00001010, 16'h5BF1));
    vecs.push_back(mk("t3_host_done",    1, 16'h5BF1, 0, 16'h4002, 1, 0, 0, 8'b01000010, 16'h5BF1));
    vecs.push_back(mk("t3_tour_issue",   1, 16'h5BF1, 0, 16'h4002, 0, 1, 0, 8'b00011110, 16'h4002));
    vecs.push_back(mk("t3_tour_wait",    1, 16'h5BF1, 0, 16'h4002, 0, 0, 1, 8'b00001110, 16'h4002));
    vecs.push_back(mk("t3_tour_ack",     1, 16'h5BF1, 0, 16'h4002, 0, 0, 0, 8'b00100110, 16'h4002));
    vecs.push_back(mk("t3_idle_strobes", 1, 16'h5BF1, 0, 16'h4002, 0, 1, 1, 8'b00000110, 16'h4002));
    vecs.push_back(mk("t3_idle_after",   1, 16'h5BF1, 0, 16'h4002, 0, 0, 0, 8'b00000110, 16'h4002));

    for (int i = 0; i < vecs.size(); i++) begin
      for (int c = 0; c < vecs[i].n; c++) begin
        tick();
        drive(vecs[i].hc, vecs[i].hr, vecs[i].tc, vecs[i].tv, vecs[i].clr, vecs[i].sr);
        #1;
        chk({vecs[i].name, "_flags"}, {24'h0, flags()}, {24'h0, vecs[i].e_flags});
        chk({vecs[i].name, "_cmd"}, {16'h0, cmd}, {16'h0, vecs[i].e_cmd});
      end
    end

    // Tour move never completed: watchdog ends it after 100 busy cycles.
    tick(); drive(16'h0, 1'b0, 16'h4001, 1'b1, 1'b0, 1'b0); #1;
    tick(); drive(16'h0, 1'b0, 16'h4001, 1'b0, 1'b0, 1'b0); #1;
    chk("t4_issue_flags", {24'h0, flags()}, {24'h0, 8'b00011110});
    chk("t4_issue_cmd", {16'h0, cmd}, 32'h4001);
    busy_cycles = 1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick(); #1;
      if (!busy) break;
      busy_cycles++;
      if (!cmd_rdy) bad++;
    end
    chk("t4_busy_cycles", busy_cycles, 100);
    chk("t4_cmd_rdy_held", bad, 0);
    chk("t4_timeout_flags", {24'h0, flags()}, {24'h0, 8'b00100111});
    tick(); #1;
    chk("t4_tmo_sticky", {24'h0, flags()}, {24'h0, 8'b00000111});
    tick(); drive(16'h5000, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0); #1;
    chk("t4_regrant", {24'h0, flags()}, {24'h0, 8'b10000111});
    tick(); drive(16'h5000, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0); #1;
    chk("t4_tmo_cleared", {24'h0, flags()}, {24'h0, 8'b00011010});
    chk("t4_regrant_cmd", {16'h0, cmd}, 32'h5000);
    tick(); drive(16'h5000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1); #1;
    chk("t4_fanfare_wait", {24'h0, flags()}, {24'h0, 8'b00001010});
    tick(); drive(16'h5000, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); #1;
    chk("t4_fanfare_done", {24'h0, flags()}, {24'h0, 8'b01000010});

    // send_resp lands on the exact timeout cycle (count 99): completion wins.
    tick(); drive(16'h4003, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0); #1;
    chk("t5_grant", {24'h0, flags()}, {24'h0, 8'b10000010});
    bad = 0;
    for (int k = 1; k < 100; k++) begin
      tick(); drive(16'h4003, 1'b0, 16'h0, 1'b0, (k == 1), 1'b0); #1;
      if (!busy || tmo_err) bad++;
    end
    chk("t5_busy_until_race", bad, 0);
    tick(); drive(16'h4003, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1); #1;
    chk("t5_race_cycle", {24'h0, flags()}, {24'h0, 8'b00001010});
    tick(); drive(16'h4003, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); #1;
    chk("t5_done_no_tmo", {24'h0, flags()}, {24'h0, 8'b01000010});

    // Async reset while waiting for completion.
    tick(); drive(16'h4004, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0);
    tick(); drive(16'h4004, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    tick(); drive(16'h4004, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); #1;
    chk("t6_in_wait", {24'h0, flags()}, {24'h0, 8'b00001010});
    tick(); rst_n = 1'b0; #1;
    chk("t6_reset_flags", {24'h0, flags()}, 32'h0);
    chk("t6_reset_cmd", {16'h0, cmd}, 32'h0);
    tick(); rst_n = 1'b1; #1;
    chk("t6_after_release", {24'h0, flags()}, 32'h0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); drive(16'h0, 1'b0, 16'h4005, 1'b1, 1'b0, 1'b0); #1;
      if (cmd_rdy || busy || cal_ok) bad++;
    end
    chk("t6_tour_blocked_again", bad, 0);
    tick(); drive(16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
